// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster constants and receiver state encoding.
package vga_pkg;

  localparam int unsigned HActive = 640;
  localparam int unsigned HFp     = 16;
  localparam int unsigned HPulse  = 96;
  localparam int unsigned HBp     = 48;
  localparam int unsigned HTotal  = HActive + HFp + HPulse + HBp;

  localparam int unsigned VActive = 480;
  localparam int unsigned VFp     = 10;
  localparam int unsigned VPulse  = 2;
  localparam int unsigned VBp     = 33;
  localparam int unsigned VTotal  = VActive + VFp + VPulse + VBp;

  // Asserted level of both syncs; 0 means active-low.
  localparam logic SyncPol = 1'b0;

  typedef enum logic [1:0] {
    StSearch,
    StAcquire,
    StLocked
  } rx_state_t;

endpackage

// File: rtl/vga_edge_det.sv
// Pixel-strobe qualified assertion-edge detector for one sync line.
module vga_edge_det #(
  parameter logic POL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pix_en,
  input  logic sync,
  output logic assert_pulse
);

  logic prev_q;

  // Previous level starts deasserted so a source already in sync yields an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= ~POL;
    end else if (pix_en) begin
      prev_q <= sync;
    end
  end

  assign assert_pulse = pix_en && (sync == POL) && (prev_q != POL);

endmodule

// File: rtl/vga_sync_rx.sv
// VGA receive-side timing recovery: rebuilds coordinates, checks line/frame
// periods and tracks lock.
module vga_sync_rx
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = HActive,
  parameter int unsigned H_PULSE     = HPulse,
  parameter int unsigned H_BP        = HBp,
  parameter int unsigned H_TOTAL     = HTotal,
  parameter int unsigned V_ACTIVE    = VActive,
  parameter int unsigned V_PULSE     = VPulse,
  parameter int unsigned V_BP        = VBp,
  parameter int unsigned V_TOTAL     = VTotal,
  parameter logic        SYNC_POL    = SyncPol,
  parameter int unsigned LOCK_FRAMES = 2,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic       clk50,
  input  logic       N_RESET,
  input  logic       VGA_CLOCK,
  input  logic       H_SYNC,
  input  logic       V_SYNC,
  output logic [9:0] XPOS,
  output logic [9:0] YPOS,
  output logic       DISP_EN,
  output logic       FRAME_START,
  output logic       LOCKED,
  output logic       H_ERR,
  output logic       V_ERR,
  output logic [7:0] ERR_COUNT
);

  localparam logic [9:0]  HStart = 10'(H_PULSE + H_BP);
  localparam logic [9:0]  HEnd   = 10'(H_PULSE + H_BP + H_ACTIVE);
  localparam logic [9:0]  VStart = 10'(V_PULSE + V_BP);
  localparam logic [9:0]  VEnd   = 10'(V_PULSE + V_BP + V_ACTIVE);
  localparam logic [10:0] HLen   = 11'(H_TOTAL);
  localparam logic [10:0] VLen   = 11'(V_TOTAL);

  localparam int unsigned IdleW = $clog2(TIMEOUT + 1);
  localparam logic [IdleW-1:0] IdleMax  = IdleW'(TIMEOUT);
  localparam logic [IdleW-1:0] IdleLast = IdleW'(TIMEOUT - 1);

  // Input sampling stage; syncs are captured alongside the pixel clock.
  logic vclk_q, vclk_q2, h_q, v_q;
  logic pix_en, h_edge, v_edge;

  logic [9:0]       hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [10:0]      line_len, frame_len;
  logic [IdleW-1:0] idle_q, idle_d;
  logic             timeout, in_win;

  rx_state_t  state_q, state_d;
  logic [7:0] good_q, good_d, good_inc;
  logic       first_q, first_d;
  logic       h_bad, v_bad;

  logic [9:0] xpos_q, ypos_q;
  logic       disp_en_q, disp_en_d, frame_start_q, h_err_q, v_err_q;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic [8:0] err_sum;

  always_ff @(posedge clk50 or negedge N_RESET) begin
    if (!N_RESET) begin
      vclk_q  <= 1'b0;
      vclk_q2 <= 1'b0;
      h_q     <= ~SYNC_POL;
      v_q     <= ~SYNC_POL;
    end else begin
      vclk_q  <= VGA_CLOCK;
      vclk_q2 <= vclk_q;
      h_q     <= H_SYNC;
      v_q     <= V_SYNC;
    end
  end

  assign pix_en = vclk_q && !vclk_q2;

  vga_edge_det #(
    .POL (SYNC_POL)
  ) u_h_edge (
    .clk          (clk50),
    .rst_n        (N_RESET),
    .pix_en       (pix_en),
    .sync         (h_q),
    .assert_pulse (h_edge)
  );

  vga_edge_det #(
    .POL (SYNC_POL)
  ) u_v_edge (
    .clk          (clk50),
    .rst_n        (N_RESET),
    .pix_en       (pix_en),
    .sync         (v_q),
    .assert_pulse (v_edge)
  );

  assign line_len  = {1'b0, hcnt_q} + 11'd1;
  assign frame_len = {1'b0, vcnt_q} + 11'd1;

  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (pix_en) begin
      if (h_edge) begin
        hcnt_d = '0;
      end else if (hcnt_q != '1) begin
        hcnt_d = hcnt_q + 10'd1;
      end
      if (v_edge) begin
        vcnt_d = '0;
      end else if (h_edge && vcnt_q != '1) begin
        vcnt_d = vcnt_q + 10'd1;
      end
    end
  end

  assign in_win = (hcnt_d >= HStart) && (hcnt_d < HEnd) &&
                  (vcnt_d >= VStart) && (vcnt_d < VEnd);

  // Fires once, on the TIMEOUT-th consecutive cycle without a strobe.
  assign timeout = !pix_en && (idle_q == IdleLast);

  always_comb begin
    idle_d = idle_q;
    if (pix_en) begin
      idle_d = '0;
    end else if (idle_q != IdleMax) begin
      idle_d = idle_q + 1'b1;
    end
  end

  assign good_inc = good_q + 8'd1;

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    first_d = first_q;
    h_bad   = 1'b0;
    v_bad   = 1'b0;
    if (timeout) begin
      state_d = StSearch;
    end else begin
      unique case (state_q)
        StSearch: begin
          if (v_edge) begin
            state_d = StAcquire;
            good_d  = '0;
            first_d = 1'b0;
          end
        end
        StAcquire, StLocked: begin
          h_bad = h_edge && first_q && (line_len != HLen);
          v_bad = v_edge && (frame_len != VLen);
          if (h_edge) begin
            first_d = 1'b1;
          end
          if (h_bad || v_bad) begin
            state_d = StSearch;
          end else if (v_edge && state_q == StAcquire) begin
            good_d = good_inc;
            if (32'(good_inc) >= LOCK_FRAMES) begin
              state_d = StLocked;
            end
          end
        end
        default: state_d = StSearch;
      endcase
    end
  end

  assign err_sum   = {1'b0, err_cnt_q} + 9'(h_bad) + 9'(v_bad);
  assign err_cnt_d = err_sum[8] ? 8'hFF : err_sum[7:0];

  // Between strobes DISP_EN holds, but a lock loss must still drop it.
  assign disp_en_d = pix_en ? ((state_d == StLocked) && in_win)
                            : (disp_en_q && (state_d == StLocked));

  always_ff @(posedge clk50 or negedge N_RESET) begin
    if (!N_RESET) begin
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      idle_q        <= '0;
      state_q       <= StSearch;
      good_q        <= '0;
      first_q       <= 1'b0;
      xpos_q        <= '0;
      ypos_q        <= '0;
      disp_en_q     <= 1'b0;
      frame_start_q <= 1'b0;
      h_err_q       <= 1'b0;
      v_err_q       <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      idle_q        <= idle_d;
      state_q       <= state_d;
      good_q        <= good_d;
      first_q       <= first_d;
      disp_en_q     <= disp_en_d;
      frame_start_q <= v_edge;
      h_err_q       <= h_bad;
      v_err_q       <= v_bad;
      err_cnt_q     <= err_cnt_d;
      if (pix_en && in_win) begin
        xpos_q <= hcnt_d - HStart;
        ypos_q <= vcnt_d - VStart;
      end
    end
  end

  assign XPOS        = xpos_q;
  assign YPOS        = ypos_q;
  assign DISP_EN     = disp_en_q;
  assign FRAME_START = frame_start_q;
  assign LOCKED      = (state_q == StLocked);
  assign H_ERR       = h_err_q;
  assign V_ERR       = v_err_q;
  assign ERR_COUNT   = err_cnt_q;

endmodule

// File: tb/tb_vga_sync_rx.sv
// Scoreboard bench for vga_sync_rx using a shrunken raster (10x6) so many
// frames fit in a short run.
module tb_vga_sync_rx;

  localparam int HA = 4;
  localparam int HP = 2;
  localparam int HB = 2;
  localparam int HT = 10;
  localparam int VA = 3;
  localparam int VP = 1;
  localparam int VB = 1;
  localparam int VT = 6;

  logic       clk50     = 1'b0;
  logic       N_RESET   = 1'b1;
  logic       VGA_CLOCK = 1'b0;
  logic       H_SYNC    = 1'b1;
  logic       V_SYNC    = 1'b1;
  logic [9:0] XPOS, YPOS;
  logic       DISP_EN, FRAME_START, LOCKED, H_ERR, V_ERR;
  logic [7:0] ERR_COUNT;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic       fs;
    logic       he;
    logic       ve;
    logic       lk;
    logic [7:0] cnt;
  } ev_t;

  ev_t         ev_q[$];
  logic [19:0] px_q[$];

  vga_sync_rx #(
    .H_ACTIVE    (HA),
    .H_PULSE     (HP),
    .H_BP        (HB),
    .H_TOTAL     (HT),
    .V_ACTIVE    (VA),
    .V_PULSE     (VP),
    .V_BP        (VB),
    .V_TOTAL     (VT),
    .SYNC_POL    (1'b0),
    .LOCK_FRAMES (2),
    .TIMEOUT     (64)
  ) dut (
    .clk50       (clk50),
    .N_RESET     (N_RESET),
    .VGA_CLOCK   (VGA_CLOCK),
    .H_SYNC      (H_SYNC),
    .V_SYNC      (V_SYNC),
    .XPOS        (XPOS),
    .YPOS        (YPOS),
    .DISP_EN     (DISP_EN),
    .FRAME_START (FRAME_START),
    .LOCKED      (LOCKED),
    .H_ERR       (H_ERR),
    .V_ERR       (V_ERR),
    .ERR_COUNT   (ERR_COUNT)
  );

  always #5 clk50 = ~clk50;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h required=%0h", name, got, exp);
    end
  endtask

  task automatic push_ev(input logic fs, input logic he, input logic ve, input logic lk,
                         input int cnt);
    ev_t e;
    e.fs  = fs;
    e.he  = he;
    e.ve  = ve;
    e.lk  = lk;
    e.cnt = 8'(cnt);
    ev_q.push_back(e);
  endtask

  task automatic pixel(input logic h, input logic v);
    @(negedge clk50);
    VGA_CLOCK = 1'b1;
    H_SYNC    = h;
    V_SYNC    = v;
    @(negedge clk50);
    VGA_CLOCK = 1'b0;
  endtask

  // en: receiver is expected to be locked through this line's active pixels.
  task automatic send_line(input int line, input int len, input bit en);
    for (int p = 0; p < len; p++) begin
      if (en && line >= VP + VB && line < VP + VB + VA && p >= HP + HB && p < HP + HB + HA)
        px_q.push_back({10'(p - HP - HB), 10'(line - VP - VB)});
      pixel((p < HP) ? 1'b0 : 1'b1, (line < VP) ? 1'b0 : 1'b1);
    end
  endtask

  task automatic send_frame(input int first, input int nlines, input int bad_line,
                            input int bad_len, input bit en);
    for (int l = first; l < nlines; l++) send_line(l, (l == bad_line) ? bad_len : HT, en);
  endtask

  // Monitor: pops an event on any pulse or lock change, a pixel on each new enabled pixel.
  logic        lk_prev = 1'b0;
  logic        de_prev = 1'b0;
  logic [19:0] xy_prev = '0;
  ev_t         got_ev, exp_ev;
  logic [19:0] exp_xy;

  always @(negedge clk50) begin
    if (N_RESET) begin
      if (FRAME_START || H_ERR || V_ERR || (LOCKED != lk_prev)) begin
        got_ev = {FRAME_START, H_ERR, V_ERR, LOCKED, ERR_COUNT};
        n_checks++;
        if (ev_q.size() == 0) begin
          n_fail++;
          $display("FAIL event_unexpected got=%h required=none", got_ev);
        end else begin
          exp_ev = ev_q.pop_front();
          if (got_ev !== exp_ev) begin
            n_fail++;
            $display("FAIL event fs/he/ve/lk/cnt got=%b/%b/%b/%b/%0d required=%b/%b/%b/%b/%0d",
                     got_ev.fs, got_ev.he, got_ev.ve, got_ev.lk, got_ev.cnt,
                     exp_ev.fs, exp_ev.he, exp_ev.ve, exp_ev.lk, exp_ev.cnt);
          end
        end
      end
      if (DISP_EN && (!de_prev || {XPOS, YPOS} != xy_prev)) begin
        n_checks++;
        if (px_q.size() == 0) begin
          n_fail++;
          $display("FAIL pixel_unexpected got x=%0d y=%0d required=none", XPOS, YPOS);
        end else begin
          exp_xy = px_q.pop_front();
          if ({XPOS, YPOS} !== exp_xy) begin
            n_fail++;
            $display("FAIL pixel got x=%0d y=%0d required x=%0d y=%0d",
                     XPOS, YPOS, exp_xy[19:10], exp_xy[9:0]);
          end
        end
      end
    end
    lk_prev = LOCKED;
    de_prev = DISP_EN;
    xy_prev = {XPOS, YPOS};
  end

  initial begin
    #2 N_RESET = 1'b0;
    repeat (3) @(negedge clk50);
    check("reset_outputs", {XPOS, YPOS, ERR_COUNT, DISP_EN, FRAME_START, LOCKED, H_ERR, V_ERR},
          32'd0);
    N_RESET = 1'b1;

    // Clean lock: partial frame, then lock on the third V edge.
    send_frame(3, VT, -1, 0, 1'b0);
    push_ev(1, 0, 0, 0, 0); send_frame(0, VT, -1, 0, 1'b0);
    push_ev(1, 0, 0, 0, 0); send_frame(0, VT, -1, 0, 1'b0);
    push_ev(1, 0, 0, 1, 0); send_frame(0, VT, -1, 0, 1'b1);
    push_ev(1, 0, 0, 1, 0); send_frame(0, VT, -1, 0, 1'b1);

    // Short first line while locked, then relock.
    push_ev(1, 0, 0, 1, 0); push_ev(0, 1, 0, 0, 1); send_frame(0, VT, 0, HT - 1, 1'b0);
    push_ev(1, 0, 0, 0, 1); send_frame(0, VT, -1, 0, 1'b0);
    push_ev(1, 0, 0, 0, 1); send_frame(0, VT, -1, 0, 1'b0);
    push_ev(1, 0, 0, 1, 1); send_frame(0, VT, -1, 0, 1'b1);

    // Long frame, relock, then long frame ending in a short line.
    push_ev(1, 0, 0, 1, 1); send_frame(0, VT + 1, -1, 0, 1'b1);
    push_ev(1, 0, 1, 0, 2); send_frame(0, VT, -1, 0, 1'b0);
    push_ev(1, 0, 0, 0, 2); send_frame(0, VT, -1, 0, 1'b0);
    push_ev(1, 0, 0, 0, 2); send_frame(0, VT, -1, 0, 1'b0);
    push_ev(1, 0, 0, 1, 2); send_frame(0, VT + 1, VT, HT - 1, 1'b1);
    push_ev(1, 1, 1, 0, 4); send_frame(0, VT, -1, 0, 1'b0);

    // Relock, then stall the pixel clock.
    push_ev(1, 0, 0, 0, 4); send_frame(0, VT, -1, 0, 1'b0);
    push_ev(1, 0, 0, 0, 4); send_frame(0, VT, -1, 0, 1'b0);
    push_ev(1, 0, 0, 1, 4); send_line(0, HT, 1'b1);
    push_ev(0, 0, 0, 0, 4);
    repeat (70) @(negedge clk50);
    check("stall_locked", {31'd0, LOCKED}, 32'd0);
    check("stall_err_count", {24'd0, ERR_COUNT}, 32'd4);
    send_frame(1, VT, -1, 0, 1'b0);
    push_ev(1, 0, 0, 0, 4); send_frame(0, VT, -1, 0, 1'b0);
    push_ev(1, 0, 0, 0, 4); send_frame(0, VT, -1, 0, 1'b0);
    push_ev(1, 0, 0, 1, 4); send_frame(0, VT, -1, 0, 1'b1);

    // Mid-frame reset while locked, then reacquire.
    push_ev(1, 0, 0, 1, 4); send_frame(0, 4, -1, 0, 1'b1);
    @(negedge clk50);
    N_RESET = 1'b0;
    #1;
    check("midframe_reset", {XPOS, YPOS, ERR_COUNT, DISP_EN, FRAME_START, LOCKED, H_ERR, V_ERR},
          32'd0);
    repeat (3) @(negedge clk50);
    N_RESET = 1'b1;
    send_frame(4, VT, -1, 0, 1'b0);
    push_ev(1, 0, 0, 0, 0); send_frame(0, VT, -1, 0, 1'b0);
    push_ev(1, 0, 0, 0, 0); send_frame(0, VT, -1, 0, 1'b0);
    push_ev(1, 0, 0, 1, 0); send_frame(0, VT, -1, 0, 1'b1);

    // Saturation: each short 3-line frame yields exactly one bad line.
    push_ev(1, 0, 0, 1, 0);
    for (int k = 1; k <= 300; k++) begin
      if (k > 1) push_ev(1, 0, 0, 0, (k - 1 > 255) ? 255 : k - 1);
      push_ev(0, 1, 0, 0, (k > 255) ? 255 : k);
      send_frame(0, 3, 1, 5, 1'b0);
    end
    repeat (20) @(negedge clk50);
    check("sat_err_count", {24'd0, ERR_COUNT}, 32'd255);
    check("events_left", ev_q.size(), 32'd0);
    check("pixels_left", px_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
